// File: rtl/alu32_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu32_pipe_if
// Description : Request/result bundle for alu32_pipe. The master drives
//               requests and consumes results; the slave is the ALU itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu32_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  control;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        overflow;
   logic        zero;
   logic        negative;
   logic [15:0] ovf_count;

   modport master (
      output in_valid, A, B, control, out_ready,
      input  in_ready, out_valid, out, overflow, zero, negative, ovf_count
   );

   modport slave (
      input  in_valid, A, B, control, out_ready,
      output in_ready, out_valid, out, overflow, zero, negative, ovf_count
   );
endinterface
`default_nettype wire

// File: rtl/alu32_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu32_pipe
// Description : 32-bit ALU (ADD/SUB/AND/OR/NOR/XOR) with a 2-entry result
//               FIFO and valid/ready handshakes on both sides. Results are
//               computed on acceptance and appear one cycle later.
//               Optional macro ALU32_PIPE_STATS_EN adds a saturating count of
//               delivered results that overflowed; otherwise ovf_count is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu32_pipe (
   input  logic        clock,
   input  logic        reset,
   alu32_pipe_if.slave bus
);

   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;
   localparam logic [2:0] ALU_OR  = 3'd5;
   localparam logic [2:0] ALU_NOR = 3'd6;
   localparam logic [2:0] ALU_XOR = 3'd7;

   // Flag bit positions inside each stored entry
   localparam int FLG_OVF = 2;
   localparam int FLG_ZER = 1;
   localparam int FLG_NEG = 0;

   logic [31:0] data_q [2];
   logic [2:0]  flag_q [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   logic        w_in_ready;
   logic        w_out_valid;
   logic        w_push;
   logic        w_pop;
   logic [31:0] w_res;
   logic        w_res_ovf;

   // Handshake status depends only on occupancy, never on out_ready
   assign w_in_ready  = (count_q != 2'd2);
   assign w_out_valid = (count_q != 2'd0);
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;

   // Combinational ALU; signed overflow from operand/result sign bits
   always_comb begin
      w_res     = '0;
      w_res_ovf = 1'b0;
      case (bus.control)
         ALU_ADD: begin
            w_res     = bus.A + bus.B;
            w_res_ovf = (bus.A[31] == bus.B[31]) && (w_res[31] != bus.A[31]);
         end
         ALU_SUB: begin
            w_res     = bus.A - bus.B;
            w_res_ovf = (bus.A[31] != bus.B[31]) && (w_res[31] != bus.A[31]);
         end
         ALU_AND: w_res = bus.A & bus.B;
         ALU_OR:  w_res = bus.A | bus.B;
         ALU_NOR: w_res = ~(bus.A | bus.B);
         ALU_XOR: w_res = bus.A ^ bus.B;
         default: begin
            w_res     = '0;
            w_res_ovf = 1'b0;
         end
      endcase
   end

   // FIFO pointer/occupancy next state; simultaneous push+pop keeps count
   always_comb begin
      wr_ptr_d = wr_ptr_q ^ w_push;
      rd_ptr_d = rd_ptr_q ^ w_pop;
      count_d  = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // FIFO state and storage; reset discards everything buffered
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         data_q[0] <= '0;
         data_q[1] <= '0;
         flag_q[0] <= '0;
         flag_q[1] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (w_push) begin
            data_q[wr_ptr_q] <= w_res;
            flag_q[wr_ptr_q] <= {w_res_ovf, (w_res == 32'd0), w_res[31]};
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out       = w_out_valid ? data_q[rd_ptr_q] : 32'd0;
   assign bus.overflow  = w_out_valid && flag_q[rd_ptr_q][FLG_OVF];
   assign bus.zero      = w_out_valid && flag_q[rd_ptr_q][FLG_ZER];
   assign bus.negative  = w_out_valid && flag_q[rd_ptr_q][FLG_NEG];

`ifdef ALU32_PIPE_STATS_EN
   logic [15:0] ovf_cnt_q;

   // Count delivered results that overflowed, sticking at all-ones
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf_cnt_q <= 16'd0;
      end else if (w_pop && flag_q[rd_ptr_q][FLG_OVF] && (ovf_cnt_q != 16'hFFFF)) begin
         ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
   end

   assign bus.ovf_count = ovf_cnt_q;
`else
   assign bus.ovf_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu32_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu32_pipe
// Description : Directed and randomized checks of alu32_pipe against an
//               arithmetic reference model with a result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu32_pipe;

   typedef struct packed {
      logic [31:0] out;
      logic        ovf;
      logic        zero;
      logic        neg;
   } res_t;

   logic clock;
   logic reset;
   int   tests;
   int   fails;

   res_t        expq[$];
   logic [15:0] ovf_m;

   alu32_pipe_if bus ();

   alu32_pipe dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference ALU: overflow judged by whether the exact signed result fits
   function automatic res_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op);
      res_t   r;
      longint s;
      r = '0;
      s = 0;
      case (op)
         3'd2: begin
            r.out = a + b;
            s     = longint'($signed(a)) + longint'($signed(b));
            r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd3: begin
            r.out = a - b;
            s     = longint'($signed(a)) - longint'($signed(b));
            r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd4: r.out = a & b;
         3'd5: r.out = a | b;
         3'd6: r.out = ~(a | b);
         3'd7: r.out = a ^ b;
         default: r.out = 32'd0;
      endcase
      r.zero = (r.out == 32'd0);
      r.neg  = r.out[31];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic ordy);
      bus.in_valid  = v;
      bus.A         = a;
      bus.B         = b;
      bus.control   = op;
      bus.out_ready = ordy;
   endtask

   // Compare all outputs with the model, then advance one clock and update it
   task automatic step();
      bit   exp_rdy;
      bit   exp_vld;
      bit   push;
      bit   pop;
      res_t h;
      res_t nr;
      exp_rdy = (expq.size() < 2);
      exp_vld = (expq.size() > 0);
      h       = exp_vld ? expq[0] : '0;
      chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_vld));
      chk("out",       bus.out,            h.out);
      chk("overflow",  32'(bus.overflow),  32'(h.ovf));
      chk("zero",      32'(bus.zero),      32'(h.zero));
      chk("negative",  32'(bus.negative),  32'(h.neg));
`ifdef ALU32_PIPE_STATS_EN
      chk("ovf_count", 32'(bus.ovf_count), 32'(ovf_m));
`else
      chk("ovf_count", 32'(bus.ovf_count), 32'd0);
`endif
      push = bus.in_valid && exp_rdy;
      pop  = bus.out_ready && exp_vld;
      nr   = ref_alu(bus.A, bus.B, bus.control);
      @(posedge clock);
      if (pop) begin
         if (expq[0].ovf && ovf_m != 16'hFFFF) ovf_m = ovf_m + 16'd1;
         void'(expq.pop_front());
      end
      if (push) expq.push_back(nr);
      @(negedge clock);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      ovf_m = 16'd0;
      reset = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0);

      // Reset state
      @(negedge clock);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out",       bus.out,            32'd0);
      chk("rst_zero",      32'(bus.zero),      32'd0);
      chk("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
      reset = 1'b1;

      // 8 + 4, accepted on the first edge after release
      drive(1'b1, 32'd8, 32'd4, 3'd2, 1'b1);
      step();
      chk("add_out",   bus.out,            32'd12);
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      chk("add_flags", {29'd0, bus.overflow, bus.zero, bus.negative}, 32'd0);

      // 0x7fffffff + 2 overflows
      drive(1'b1, 32'h7fffffff, 32'd2, 3'd2, 1'b1);
      step();
      drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
      chk("ovf_out", bus.out,           32'h80000001);
      chk("ovf_flg", 32'(bus.overflow), 32'd1);
      chk("ovf_neg", 32'(bus.negative), 32'd1);
      step();
`ifdef ALU32_PIPE_STATS_EN
      chk("ovf_count_pop", 32'(bus.ovf_count), 32'd1);
`else
      chk("ovf_count_pop", 32'(bus.ovf_count), 32'd0);
`endif

      // 7 - 7 and NOR of 17, 356
      drive(1'b1, 32'd7, 32'd7, 3'd3, 1'b1);
      step();
      chk("sub_out",  bus.out,        32'd0);
      chk("sub_zero", 32'(bus.zero),  32'd1);
      drive(1'b1, 32'd17, 32'd356, 3'd6, 1'b1);
      step();
      chk("nor_out", bus.out,            32'hFFFFFE8A);
      chk("nor_neg", 32'(bus.negative),  32'd1);

      // Invalid opcode 0
      drive(1'b1, 32'd5, 32'd9, 3'd0, 1'b1);
      step();
      chk("inv_out",  bus.out,           32'd0);
      chk("inv_zero", 32'(bus.zero),     32'd1);
      chk("inv_ovf",  32'(bus.overflow), 32'd0);
      chk("inv_neg",  32'(bus.negative), 32'd0);
      drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
      step();

      // Backpressure: 1+1, 2+2 fill the FIFO, 3+3 is held
      drive(1'b1, 32'd1, 32'd1, 3'd2, 1'b0);
      step();
      drive(1'b1, 32'd2, 32'd2, 3'd2, 1'b0);
      step();
      chk("bp_full", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 32'd3, 32'd3, 3'd2, 1'b0);
      step();
      chk("bp_hold", bus.out, 32'd2);
      bus.out_ready = 1'b1;
      chk("bp_r0", bus.out, 32'd2);
      step();
      chk("bp_r1", bus.out, 32'd4);
      step();
      drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
      chk("bp_r2", bus.out, 32'd6);
      step();
      chk("bp_empty", 32'(bus.out_valid), 32'd0);

      // Reset mid-operation with two entries buffered
      drive(1'b1, 32'd10, 32'd20, 3'd2, 1'b0);
      step();
      drive(1'b1, 32'd30, 32'd40, 3'd5, 1'b0);
      step();
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_ready", 32'(bus.in_ready),  32'd1);
      chk("mid_rst_out",   bus.out,            32'd0);
      reset = 1'b1;
      expq.delete();
      ovf_m = 16'd0;
      #1;
      drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
      step();
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? a : $urandom;
         drive($urandom_range(0, 3) != 0, a, b, 3'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0);
         step();
      end
      drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
      step();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
